regfile_mp: RTL

//  Parametrised multi-read-port register file for the single-cycle/pipelined CPU datapath.

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: read ports, writeback port, alloc port and clear control.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pending;
    logic                         regwrite;
    logic [ADDR_WIDTH-1:0]        register_w;
    logic [DATA_WIDTH-1:0]        write_data;
    logic                         write_ready;
    logic                         alloc_valid;
    logic [ADDR_WIDTH-1:0]        alloc_addr;
    logic                         clear_req;
    logic                         clear_busy;

    // Datapath side: issues reads, writebacks, allocations and clear requests
    modport master (
        output rd_addr, regwrite, register_w, write_data, alloc_valid, alloc_addr, clear_req,
        input  rd_data, rd_pending, write_ready, clear_busy
    );

    // Register file side
    modport slave (
        input  rd_addr, regwrite, register_w, write_data, alloc_valid, alloc_addr, clear_req,
        output rd_data, rd_pending, write_ready, clear_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register pending bits and a hardware clear sweep.
// Optional macro RF_BYPASS_EN: forward an accepted write to matching read ports in the same cycle.
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned            DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]        pend_q, pend_d;

    logic                    write_ready_c;
    logic                    wr_en_c;
    logic                    alloc_en_c;

    // Writes and allocations are only accepted while no sweep is running
    assign write_ready_c = (state_q == ST_IDLE);
    assign wr_en_c       = bus.regwrite    & write_ready_c & (bus.register_w != '0);
    assign alloc_en_c    = bus.alloc_valid & write_ready_c & (bus.alloc_addr != '0);

    assign bus.write_ready = write_ready_c;
    assign bus.clear_busy  = (state_q == ST_CLEAR);

    // Sweep FSM next state: IDLE -> CLEAR on clear_req, walk registers 1..DEPTH-1
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = ADDR_WIDTH'(1);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage and pending next state; a same-cycle alloc overrides the write's pending clear
    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr_en_c) begin
            mem_d[bus.register_w]  = bus.write_data;
            pend_d[bus.register_w] = 1'b0;
        end
        if (alloc_en_c) begin
            pend_d[bus.alloc_addr] = 1'b1;
        end
        if ((state_q == ST_IDLE) && bus.clear_req) begin
            pend_d = '0;
        end
        if (state_q == ST_CLEAR) begin
            mem_d[cnt_q] = '0;
        end
        mem_d[0]  = '0;
        pend_d[0] = 1'b0;
    end

    // FSM and pending state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Register array
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = bus.rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef RF_BYPASS_EN
        logic hit;
        assign hit = wr_en_c && (ra == bus.register_w);
        assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = hit ? bus.write_data : mem_q[ra];
        assign bus.rd_pending[k] = hit ? (alloc_en_c && (bus.alloc_addr == ra)) : pend_q[ra];
`else
        assign bus.rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
        assign bus.rd_pending[k] = pend_q[ra];
`endif
    end

endmodule
